// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan/decode path: segment patterns,
// the capture FSM state type and the one-hot digit-enable helper.
package seg7_pkg;

   // Segment patterns on seg[6:0], a = bit 6 ... g = bit 0, active-high.
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] DIG_INVALID = 4'hF;

   typedef enum logic [1:0] {IDLE, QUALIFY, HOLD} cap_state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } onehot_t;

   // Digit enables are at most 8 wide; callers zero-extend narrower buses.
   function automatic onehot_t onehot_index(input logic [7:0] v);
      onehot_t r;
      r.valid = (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
      r.idx   = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) r.idx = 3'(i);
      return r;
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Inverse of the BCD-to-7-segment encoder table: maps a segment pattern back
// to its digit, flagging the all-off pattern as blank and anything else as err.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       blank,
   output logic       err
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      digit = DIG_INVALID;
      blank = 1'b0;
      err   = 1'b0;
      case (seg)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: blank = 1'b1;
         default:   err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads a multiplexed 7-segment bus back into BCD: each digit is captured after
// a stable dwell, and a full NDIG-digit frame is offered on a valid/ready port.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NDIG          = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NDIG-1:0]   an,
   input  logic [7:0]        seg,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [4*NDIG-1:0] out_digits,
   output logic [NDIG-1:0]   out_blank,
   output logic [NDIG-1:0]   out_err,
   output logic              out_overrun
);

   localparam int            CW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam bit            SINGLE   = (STABLE_CYCLES == 1);
   localparam logic [NDIG-1:0] MASK_FULL = '1;

   cap_state_t        state;
   logic [NDIG-1:0]   prev_an;
   logic [6:0]        prev_seg;
   logic [CW-1:0]     cnt;
   logic [NDIG-1:0]   mask;

   logic [4*NDIG-1:0] work_digits, frm_digits, wd_nxt;
   logic [NDIG-1:0]   work_blank, frm_blank, wb_nxt;
   logic [NDIG-1:0]   work_err, frm_err, we_nxt;
   logic              frm_done;

   onehot_t           oh;
   logic              same_pair, capture;
   logic [NDIG-1:0]   sel, mask_nxt;
   logic [3:0]        dec_digit;
   logic              dec_blank, dec_err;
   logic              unused_dp;

   assign unused_dp = seg[7];
   assign oh        = onehot_index(8'(an));
   assign same_pair = (an == prev_an) && (seg[6:0] == prev_seg);

   seg7_to_bcd u_dec (
      .seg   (seg[6:0]),
      .digit (dec_digit),
      .blank (dec_blank),
      .err   (dec_err)
   );

   // A capture happens when the dwell count is about to reach STABLE_CYCLES,
   // or on the very first cycle of a new pair when one cycle is enough.
   always_comb begin
      capture = 1'b0;
      case (state)
         IDLE:    capture = oh.valid && SINGLE;
         QUALIFY: capture = oh.valid && (same_pair ? (cnt >= CNT_LAST) : SINGLE);
         HOLD:    capture = oh.valid && !same_pair && SINGLE;
         default: capture = 1'b0;
      endcase
   end

   always_comb begin
      sel = '0;
      if (oh.valid) sel = NDIG'(1) << oh.idx;
      mask_nxt = mask | sel;
      wd_nxt   = work_digits;
      wb_nxt   = work_blank;
      we_nxt   = work_err;
      for (int i = 0; i < NDIG; i++) begin
         if (sel[i]) begin
            wd_nxt[4*i +: 4] = dec_digit;
            wb_nxt[i]        = dec_blank;
            we_nxt[i]        = dec_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: working and frame registers are cleared too, so a reset mid-frame
         // cannot leak stale digits into a later frame.
         state       <= IDLE;
         prev_an     <= '0;
         prev_seg    <= '0;
         cnt         <= '0;
         mask        <= '0;
         work_digits <= '0;
         work_blank  <= '0;
         work_err    <= '0;
         frm_digits  <= '0;
         frm_blank   <= '0;
         frm_err     <= '0;
         frm_done    <= 1'b0;
         out_valid   <= 1'b0;
         out_digits  <= '0;
         out_blank   <= '0;
         out_err     <= '0;
         out_overrun <= 1'b0;
      end else begin
         // NOTE: all state updates use <= so every branch sees pre-edge values.
         frm_done <= 1'b0;

         case (state)
            IDLE: begin
               if (oh.valid) begin
                  prev_an  <= an;
                  prev_seg <= seg[6:0];
                  cnt      <= CNT_ONE;
                  state    <= capture ? HOLD : QUALIFY;
               end
            end
            QUALIFY: begin
               if (!oh.valid) begin
                  state <= IDLE;
               end else if (!same_pair) begin
                  prev_an  <= an;
                  prev_seg <= seg[6:0];
                  cnt      <= CNT_ONE;
                  state    <= capture ? HOLD : QUALIFY;
               end else begin
                  if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                  if (capture) state <= HOLD;
               end
            end
            HOLD: begin
               if (!oh.valid) begin
                  state <= IDLE;
               end else if (!same_pair) begin
                  prev_an  <= an;
                  prev_seg <= seg[6:0];
                  cnt      <= CNT_ONE;
                  state    <= capture ? HOLD : QUALIFY;
               end
            end
            default: state <= IDLE;
         endcase

         // The completed frame is snapshotted so a capture on the load edge
         // cannot disturb what gets presented.
         if (capture) begin
            work_digits <= wd_nxt;
            work_blank  <= wb_nxt;
            work_err    <= we_nxt;
            if (mask_nxt == MASK_FULL) begin
               mask       <= '0;
               frm_digits <= wd_nxt;
               frm_blank  <= wb_nxt;
               frm_err    <= we_nxt;
               frm_done   <= 1'b1;
            end else begin
               mask <= mask_nxt;
            end
         end

         if (frm_done) begin
            out_valid   <= 1'b1;
            out_digits  <= frm_digits;
            out_blank   <= frm_blank;
            out_err     <= frm_err;
            out_overrun <= out_valid && !out_ready;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: a run-length model of digit capture and frame
// delivery checked every cycle, plus directed scans with literal expectations.
module tb_seg7_scan_decoder;

   localparam int NDIG   = 4;
   localparam int STABLE = 4;

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
   localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
   localparam logic [6:0] S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111;
   localparam logic [6:0] S9 = 7'b1111011, SOFF = 7'b0000000, SBAD = 7'b1000000;

   logic              clk = 1'b0;
   logic              rst;
   logic [NDIG-1:0]   an;
   logic [7:0]        seg;
   logic              out_ready;
   logic              out_valid;
   logic [4*NDIG-1:0] out_digits;
   logic [NDIG-1:0]   out_blank, out_err;
   logic              out_overrun;

   int n_checks = 0;
   int n_err    = 0;

   // Model state: run length of the current one-hot pair, partial frame,
   // completed frame pending load, and the presented outputs.
   int                run = 0;
   logic              last_oh = 1'b0;
   logic [NDIG-1:0]   last_an = '0;
   logic [6:0]        last_seg = '0;
   logic [NDIG-1:0]   m_mask = '0;
   logic [15:0]       s_digits = '0, p_digits = '0, m_digits = '0;
   logic [NDIG-1:0]   s_blank = '0, p_blank = '0, m_blank = '0;
   logic [NDIG-1:0]   s_err = '0, p_err = '0, m_err = '0;
   logic              m_pend = 1'b0, m_valid = 1'b0, m_ov = 1'b0;

   // Accepted-frame record taken from the DUT's handshake.
   int                acc_cnt = 0;
   logic [15:0]       acc_digits = '0;
   logic [NDIG-1:0]   acc_blank = '0, acc_err = '0;
   logic              acc_ov = 1'b0;
   logic              dp_t = 1'b0;

   seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .seg         (seg),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_digits  (out_digits),
      .out_blank   (out_blank),
      .out_err     (out_err),
      .out_overrun (out_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic decode(input logic [6:0] s, output logic [3:0] d, output logic b, output logic e);
      logic [6:0] tbl [10];
      tbl = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
      d = 4'hF;
      b = 1'b0;
      e = 1'b0;
      if (s == 7'd0) b = 1'b1;
      else begin
         e = 1'b1;
         for (int i = 0; i < 10; i++)
            if (s == tbl[i]) begin
               d = 4'(i);
               e = 1'b0;
            end
      end
   endtask

   task automatic model_step();
      logic       oh;
      int         k;
      logic [3:0] d;
      logic       b, e;
      if (rst) begin
         run = 0; last_oh = 0; last_an = '0; last_seg = '0; m_mask = '0;
         s_digits = '0; s_blank = '0; s_err = '0;
         p_digits = '0; p_blank = '0; p_err = '0; m_pend = 0;
         m_valid = 0; m_digits = '0; m_blank = '0; m_err = '0; m_ov = 0;
      end else begin
         if (m_pend) begin
            m_ov     = m_valid && !out_ready;
            m_valid  = 1'b1;
            m_digits = p_digits;
            m_blank  = p_blank;
            m_err    = p_err;
            m_pend   = 1'b0;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         oh = ($countones(an) == 1);
         if (oh && last_oh && an == last_an && seg[6:0] == last_seg) run++;
         else run = oh ? 1 : 0;
         last_oh = oh; last_an = an; last_seg = seg[6:0];
         if (run == STABLE) begin
            k = 0;
            for (int i = 0; i < NDIG; i++) if (an[i]) k = i;
            decode(seg[6:0], d, b, e);
            s_digits[4*k +: 4] = d;
            s_blank[k] = b;
            s_err[k]   = e;
            m_mask[k]  = 1'b1;
            if (&m_mask) begin
               p_digits = s_digits; p_blank = s_blank; p_err = s_err;
               m_pend = 1'b1;
               m_mask = '0;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison plus handshake recording, away from the active edge.
   initial forever begin
      @(negedge clk);
      check("valid",   32'(out_valid),   32'(m_valid));
      check("digits",  32'(out_digits),  32'(m_digits));
      check("blank",   32'(out_blank),   32'(m_blank));
      check("err",     32'(out_err),     32'(m_err));
      check("overrun", 32'(out_overrun), 32'(m_ov));
      if (!rst && out_valid && out_ready) begin
         acc_cnt++;
         acc_digits = out_digits;
         acc_blank  = out_blank;
         acc_err    = out_err;
         acc_ov     = out_overrun;
      end
   end

   task automatic drive(input logic [NDIG-1:0] a, input logic [6:0] s, input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         dp_t = ~dp_t;
         an   = a;
         seg  = {dp_t, s};
      end
   endtask

   task automatic scan4(input logic [6:0] d0, input logic [6:0] d1,
                        input logic [6:0] d2, input logic [6:0] d3, input int n);
      drive(4'b0001, d0, n);
      drive(4'b0010, d1, n);
      drive(4'b0100, d2, n);
      drive(4'b1000, d3, n);
   endtask

   initial begin
      int a0;
      rst = 1'b1; an = '0; seg = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid",  32'(out_valid),   32'd0);
      check("reset_digits", 32'(out_digits),  32'd0);
      check("reset_ovr",    32'(out_overrun), 32'd0);
      rst = 1'b0;
      drive('0, SOFF, 3);

      // Scan 3,1,4,1 with 6-cycle dwells; watch the exact valid timing.
      a0 = acc_cnt;
      drive(4'b0001, S3, 6);
      drive(4'b0010, S1, 6);
      drive(4'b0100, S4, 6);
      drive(4'b1000, S1, 4);
      drive(4'b1000, S1, 1);
      check("t1_valid_before", 32'(out_valid), 32'd0);
      drive(4'b1000, S1, 1);
      check("t1_valid_rise", 32'(out_valid),  32'd1);
      check("t1_digits",     32'(out_digits), 32'h1413);
      check("t1_err",        32'(out_err),    32'h0);
      check("t1_blank",      32'(out_blank),  32'h0);
      drive('0, SOFF, 3);
      check("t1_one_frame", 32'(acc_cnt - a0), 32'd1);

      // Glitch: a 3-cycle pattern on digit 1 must not be captured.
      drive(4'b0001, S5, 5);
      drive(4'b0010, S2, 3);
      drive(4'b0010, S3, 4);
      drive(4'b0100, S7, 5);
      drive(4'b1000, S9, 5);
      drive('0, SOFF, 3);
      check("t2_digits", 32'(acc_digits), 32'h9735);

      // Invalid pattern on digit 0, blank on digit 2.
      scan4(SBAD, S8, SOFF, S0, 5);
      drive('0, SOFF, 3);
      check("t3_digits", 32'(acc_digits), 32'h0F8F);
      check("t3_blank",  32'(acc_blank),  32'b0100);
      check("t3_err",    32'(acc_err),    32'b0001);

      // Multi-hot and zero enables mid-frame capture nothing.
      a0 = acc_cnt;
      drive(4'b0001, S2, 5);
      drive(4'b0010, S6, 5);
      drive(4'b0011, S8, 10);
      drive(4'b0000, S8, 10);
      check("t4_no_frame", 32'(acc_cnt - a0), 32'd0);
      drive(4'b0100, S4, 5);
      drive(4'b1000, S1, 5);
      drive('0, SOFF, 3);
      check("t4_one_frame", 32'(acc_cnt - a0), 32'd1);
      check("t4_digits",    32'(acc_digits),   32'h1462);

      // Backpressure across two frames, then a single-cycle accept.
      out_ready = 1'b0;
      scan4(S4, S3, S2, S1, 5);
      drive('0, SOFF, 2);
      check("t5_f1_valid",  32'(out_valid),   32'd1);
      check("t5_f1_digits", 32'(out_digits),  32'h1234);
      check("t5_f1_ovr",    32'(out_overrun), 32'd0);
      scan4(S8, S7, S6, S5, 5);
      drive('0, SOFF, 2);
      check("t5_f2_valid",  32'(out_valid),   32'd1);
      check("t5_f2_digits", 32'(out_digits),  32'h5678);
      check("t5_f2_ovr",    32'(out_overrun), 32'd1);
      out_ready = 1'b1;
      drive('0, SOFF, 1);
      check("t5_accept_fall", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      scan4(S8, S6, S4, S2, 5);
      drive('0, SOFF, 2);
      check("t5_f3_valid",  32'(out_valid),   32'd1);
      check("t5_f3_digits", 32'(out_digits),  32'h2468);
      check("t5_f3_ovr",    32'(out_overrun), 32'd0);
      out_ready = 1'b1;
      drive('0, SOFF, 3);

      // Reset after two captures: partial mask must be discarded.
      drive(4'b0001, S1, 5);
      drive(4'b0010, S2, 5);
      rst = 1'b1;
      drive('0, SOFF, 2);
      check("t6_rst_valid",  32'(out_valid),   32'd0);
      check("t6_rst_digits", 32'(out_digits),  32'd0);
      check("t6_rst_blank",  32'(out_blank),   32'd0);
      rst = 1'b0;
      a0 = acc_cnt;
      drive(4'b0100, S9, 5);
      drive(4'b1000, S3, 5);
      drive('0, SOFF, 3);
      check("t6_partial_no_frame", 32'(acc_cnt - a0), 32'd0);
      drive(4'b0001, S7, 5);
      drive(4'b0010, S8, 5);
      drive('0, SOFF, 3);
      check("t6_one_frame", 32'(acc_cnt - a0), 32'd1);
      check("t6_digits",    32'(acc_digits),   32'h3987);
      check("t6_ovr",       32'(acc_ov),       32'd0);

      drive('0, SOFF, 2);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
